key_beep_pattern: RTL and testbench

//  Consumes the debounced key stream (key_value/key_flag) from key_debounce and drives the

---
 rtl/key_beep_pattern_if.sv | 17 +
 rtl/key_beep_pattern.sv | 146 ++++++++++++++
 tb/tb_key_beep_pattern.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/key_beep_pattern_if.sv
// Key-to-buzzer link between key_debounce and the beep pattern player.
//   key_value : debounced key level, 0 = pressed, 1 = released
//   key_flag  : 1-cycle pulse, key_value has just settled at a new level
//   beep      : buzzer drive, a square wave during bursts, 0 otherwise
//   busy      : 1 while a beep pattern is playing
// Handshake: key_flag is a plain strobe with no back-pressure. The consumer
// samples key_value on every rising clock edge where key_flag is 1. A release
// that arrives while busy is 1 is still tracked, but it does not start a pattern.
interface key_beep_pattern_if;
    logic key_value;
    logic key_flag;
    logic beep;
    logic busy;

    modport master (output key_value, output key_flag, input beep, input busy);
    modport slave  (input key_value, input key_flag, output beep, output busy);
endinterface

// File: rtl/key_beep_pattern.sv
// Key beep pattern player. It classifies each key press as short or long,
// based on how long the key was held. When the key is released and no
// pattern is playing, it plays SHORT_BEEPS or LONG_BEEPS tone bursts.
// Each burst lasts ON_CYC cycles, and bursts are separated by OFF_CYC
// silent cycles.
//   sys_clk  : system clock, rising edge
//   sys_rst  : asynchronous, active-high reset
//   kb       : key stream in (key_value/key_flag), buzzer out (beep/busy)
//   state_o  : current FSM state, for observation (0 IDLE, 1 ON, 2 OFF)
module key_beep_pattern #(
    parameter int TONE_HALF   = 12500,
    parameter int ON_CYC      = 5000000,
    parameter int OFF_CYC     = 5000000,
    parameter int LONG_CYC    = 50000000,
    parameter int SHORT_BEEPS = 1,
    parameter int LONG_BEEPS  = 3
) (
    input  logic                 sys_clk,
    input  logic                 sys_rst,
    key_beep_pattern_if.slave    kb,
    output logic [1:0]           state_o
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ON   = 2'd1,
        OFF  = 2'd2
    } state_t;

    localparam int DUR_MAX = (ON_CYC > OFF_CYC) ? ON_CYC : OFF_CYC;
    localparam int TONE_W  = $clog2(TONE_HALF + 1);
    localparam int DUR_W   = $clog2(DUR_MAX + 1);
    localparam int PRESS_W = $clog2(LONG_CYC + 1);

    localparam logic [TONE_W-1:0]  TONE_LAST = TONE_W'(TONE_HALF - 1);
    localparam logic [DUR_W-1:0]   ON_LAST   = DUR_W'(ON_CYC - 1);
    localparam logic [DUR_W-1:0]   OFF_LAST  = DUR_W'(OFF_CYC - 1);
    localparam logic [PRESS_W-1:0] PRESS_SAT = PRESS_W'(LONG_CYC);
    localparam logic [3:0]         N_SHORT   = 4'(SHORT_BEEPS);
    localparam logic [3:0]         N_LONG    = 4'(LONG_BEEPS);

    state_t               state_q;
    logic                 beep_q;
    logic                 busy_q;
    logic                 pressed_q;
    logic [PRESS_W-1:0]   press_cnt_q;
    logic [3:0]           beeps_left_q;
    logic [TONE_W-1:0]    tone_cnt_q;
    logic [DUR_W-1:0]     dur_cnt_q;

    logic press_ev;
    logic release_ev;
    logic is_long;
    logic request;

    assign press_ev   = kb.key_flag & ~kb.key_value;
    // A release only counts when a press was seen first.
    assign release_ev = kb.key_flag & kb.key_value & pressed_q;
    // On the release edge, press_cnt_q holds the hold time. It saturates at
    // LONG_CYC, so this compare is the long/short decision.
    assign is_long    = (press_cnt_q >= PRESS_SAT);
    assign request    = release_ev & (state_q == IDLE);

    assign kb.beep = beep_q;
    assign kb.busy = busy_q;
    assign state_o = state_q;

    // Press duration tracking runs regardless of the pattern player.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            pressed_q   <= 1'b0;
            press_cnt_q <= '0;
        end else if (press_ev) begin
            pressed_q   <= 1'b1;
            press_cnt_q <= PRESS_W'(1);
        end else if (release_ev) begin
            pressed_q   <= 1'b0;
        end else if (pressed_q && !kb.key_flag && press_cnt_q < PRESS_SAT) begin
            press_cnt_q <= press_cnt_q + PRESS_W'(1);
        end
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state_q      <= IDLE;
            beep_q       <= 1'b0;
            busy_q       <= 1'b0;
            beeps_left_q <= '0;
            tone_cnt_q   <= '0;
            dur_cnt_q    <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    beep_q <= 1'b0;
                    busy_q <= 1'b0;
                    if (request) begin
                        state_q      <= ON;
                        busy_q       <= 1'b1;
                        beep_q       <= 1'b1;
                        beeps_left_q <= is_long ? N_LONG : N_SHORT;
                        tone_cnt_q   <= '0;
                        dur_cnt_q    <= '0;
                    end
                end
                ON: begin
                    if (dur_cnt_q == ON_LAST) begin
                        // The end of a burst takes priority over the tone toggle,
                        // so each burst always ends with beep low.
                        beep_q       <= 1'b0;
                        beeps_left_q <= beeps_left_q - 4'd1;
                        dur_cnt_q    <= '0;
                        if (beeps_left_q == 4'd1) begin
                            state_q <= IDLE;
                            busy_q  <= 1'b0;
                        end else begin
                            state_q <= OFF;
                        end
                    end else begin
                        dur_cnt_q <= dur_cnt_q + DUR_W'(1);
                        if (tone_cnt_q == TONE_LAST) begin
                            beep_q     <= ~beep_q;
                            tone_cnt_q <= '0;
                        end else begin
                            tone_cnt_q <= tone_cnt_q + TONE_W'(1);
                        end
                    end
                end
                OFF: begin
                    beep_q <= 1'b0;
                    if (dur_cnt_q == OFF_LAST) begin
                        state_q    <= ON;
                        beep_q     <= 1'b1;
                        tone_cnt_q <= '0;
                        dur_cnt_q  <= '0;
                    end else begin
                        dur_cnt_q <= dur_cnt_q + DUR_W'(1);
                    end
                end
                default: begin
                    state_q <= IDLE;
                    beep_q  <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_key_beep_pattern.sv
module tb_key_beep_pattern;
  localparam int TH   = 4;
  localparam int ONC  = 32;
  localparam int OFFC = 16;
  localparam int LNG  = 100;
  localparam int NS   = 1;
  localparam int NL   = 3;

  logic       clk;
  logic       rst;
  logic [1:0] state_dbg;
  key_beep_pattern_if kb_if();

  key_beep_pattern #(
    .TONE_HALF(TH), .ON_CYC(ONC), .OFF_CYC(OFFC),
    .LONG_CYC(LNG), .SHORT_BEEPS(NS), .LONG_BEEPS(NL)
  ) dut (
    .sys_clk(clk),
    .sys_rst(rst),
    .kb(kb_if.slave),
    .state_o(state_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // behavioural model: a pattern is fully described by its start edge and
  // burst count; outputs are plain arithmetic on the offset from that edge
  int  e_cnt = 0;
  bit  have_pat = 0;
  int  r_edge = 0;
  int  n_b = 0;
  bit  pressed_m = 0;
  int  t_press = 0;

  function automatic void exp_at(input int e, output bit b, output bit bz);
    int k, len, phase;
    b = 0;
    bz = 0;
    if (have_pat && e >= r_edge) begin
      k = e - r_edge;
      len = n_b * ONC + (n_b - 1) * OFFC;
      if (k < len) begin
        bz = 1;
        phase = k % (ONC + OFFC);
        b = (phase < ONC) && (((phase / TH) % 2) == 0);
      end
    end
  endfunction

  always @(posedge clk or posedge rst) begin
    bit pb, pbz;
    if (rst) begin
      have_pat = 0;
      pressed_m = 0;
    end else begin
      exp_at(e_cnt, pb, pbz);
      e_cnt = e_cnt + 1;
      if (kb_if.key_flag && !kb_if.key_value) begin
        pressed_m = 1;
        t_press = e_cnt;
      end else if (kb_if.key_flag && kb_if.key_value && pressed_m) begin
        pressed_m = 0;
        if (!pbz) begin
          have_pat = 1;
          r_edge = e_cnt;
          n_b = ((e_cnt - t_press) >= LNG) ? NL : NS;
        end
      end
    end
  end

  // scoreboard: compare every cycle on the falling edge, tally measurements
  int busy_total = 0;
  int rise_total = 0;
  initial begin
    bit eb, ebz;
    logic prev_beep;
    prev_beep = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_beep = 1'b0;
      end else begin
        exp_at(e_cnt, eb, ebz);
        check("beep", int'(kb_if.beep), int'(eb));
        check("busy", int'(kb_if.busy), int'(ebz));
        if (kb_if.busy) busy_total++;
        if (kb_if.beep && !prev_beep) rise_total++;
        prev_beep = kb_if.beep;
      end
    end
  end

  // driver tasks
  task automatic pulse(input logic val);
    kb_if.key_value = val;
    kb_if.key_flag = 1'b1;
    @(posedge clk);
    #1;
    kb_if.key_flag = 1'b0;
  endtask

  task automatic press_release(input int d);
    pulse(1'b0);
    repeat (d - 1) @(posedge clk);
    #1;
    pulse(1'b1);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    #2;
    rst = 1'b1;
    #1;
    check("rst_beep", int'(kb_if.beep), 0);
    check("rst_busy", int'(kb_if.busy), 0);
    check("rst_state", int'(state_dbg), 0);
    idle(2);
    rst = 1'b0;
    idle(1);
  endtask

  int b0, r0;

  initial begin
    rst = 1'b0;
    kb_if.key_value = 1'b1;
    kb_if.key_flag = 1'b0;
    do_reset();

    // 6: release only after reset -> nothing
    b0 = busy_total; r0 = rise_total;
    pulse(1'b1);
    idle(60);
    check("stray_rel_busy", busy_total - b0, 0);
    check("stray_rel_rises", rise_total - r0, 0);

    // 1: short press
    b0 = busy_total; r0 = rise_total;
    press_release(20);
    check("short_beep_first", int'(kb_if.beep), 1);
    idle(150);
    check("short_busy_cycles", busy_total - b0, 32);
    check("short_rises", rise_total - r0, 4);
    check("short_beep_after", int'(kb_if.beep), 0);

    // 2: long press
    b0 = busy_total; r0 = rise_total;
    press_release(150);
    idle(200);
    check("long_busy_cycles", busy_total - b0, 128);
    check("long_rises", rise_total - r0, 12);

    // 3: boundary
    b0 = busy_total; r0 = rise_total;
    press_release(99);
    idle(100);
    check("d99_busy_cycles", busy_total - b0, 32);
    check("d99_rises", rise_total - r0, 4);
    b0 = busy_total; r0 = rise_total;
    press_release(100);
    idle(200);
    check("d100_busy_cycles", busy_total - b0, 128);
    check("d100_rises", rise_total - r0, 12);

    // 4: press+release during burst 2 of a long pattern is discarded
    b0 = busy_total; r0 = rise_total;
    press_release(150);
    idle(50);
    press_release(20);
    idle(250);
    check("busy_rel_cycles", busy_total - b0, 128);
    check("busy_rel_rises", rise_total - r0, 12);

    // 5: async reset mid-ON, then a release with no press
    press_release(150);
    idle(10);
    do_reset();
    b0 = busy_total; r0 = rise_total;
    pulse(1'b1);
    idle(80);
    check("post_rst_busy", busy_total - b0, 0);
    check("post_rst_rises", rise_total - r0, 0);

    // randomized presses and releases, checked cycle by cycle
    for (int i = 0; i < 40; i++) begin
      int d;
      idle($urandom_range(0, 140));
      if ($urandom_range(0, 7) == 0) begin
        pulse(1'b1);
      end else begin
        d = ($urandom_range(0, 3) == 0) ? $urandom_range(95, 105) : $urandom_range(1, 220);
        press_release(d);
      end
    end
    idle(200);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
